// File: rtl/lsp.sv
// lsp: load/store pipe.
//   Accepts one load/store op at a time from issue (ix_lsp_*). It forms the byte address
//   base + sext(offset), issues a single data-memory request (dm_req_*), waits for the one
//   response (dm_resp_*), extracts and extends load data, and presents the load result on the
//   writeback interface (lsp_ix_*). lsp_ix_mem_* publish the in-flight load destination so issue
//   can stall dependents.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ix_lsp_*              op input and ready (ready is a registered decode of M == IDLE)
//   lsp_ix_mem_wb_en/dst  in-flight load destination
//   lsp_ix_*              writeback register W (valid held until lsp_ix_ready)
//   dm_req_*/dm_resp_*    data-memory request/response, one response per request, in order
// Build option LSP_MISALIGN_TRAP_EN:
//   defined   - misaligned ops skip memory (loads write back 0, stores retire) and are reported
//               on lsp_misalign / lsp_misalign_pc.
//   undefined - addresses are aligned down to the access size; no misalign ports.
module lsp (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ix_lsp_pc,
  input  logic [4:0]  ix_lsp_dst,
  input  logic        ix_lsp_wb_en,
  input  logic [63:0] ix_lsp_base,
  input  logic [11:0] ix_lsp_offset,
  input  logic [63:0] ix_lsp_source,
  input  logic        ix_lsp_mem_sign,
  input  logic [1:0]  ix_lsp_mem_width,
  input  logic        ix_lsp_valid,
  output logic        ix_lsp_ready,
  output logic        lsp_ix_mem_wb_en,
  output logic [4:0]  lsp_ix_mem_dst,
  output logic [4:0]  lsp_ix_dst,
  output logic [63:0] lsp_ix_result,
  output logic [63:0] lsp_ix_pc,
  output logic        lsp_ix_wb_en,
  output logic        lsp_ix_valid,
  input  logic        lsp_ix_ready,
  output logic        dm_req_valid,
  input  logic        dm_req_ready,
  output logic [63:0] dm_req_addr,
  output logic        dm_req_wen,
  output logic [63:0] dm_req_wdata,
  output logic [7:0]  dm_req_wmask,
  input  logic        dm_resp_valid,
  input  logic [63:0] dm_resp_rdata
`ifdef LSP_MISALIGN_TRAP_EN
  ,
  output logic        lsp_misalign,
  output logic [63:0] lsp_misalign_pc
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StHold} m_state_e;

  m_state_e    r_state;
  logic        r_ready;
  logic [63:0] r_addr;
  logic [7:0]  r_wmask;
  logic [63:0] r_wdata;
  logic [1:0]  r_width;
  logic        r_sign;
  logic [4:0]  r_dst;
  logic [63:0] r_pc;
  logic        r_wb_en;
  logic        r_store;
  logic [63:0] r_result;

  logic        r_w_valid;
  logic [4:0]  r_w_dst;
  logic [63:0] r_w_result;
  logic [63:0] r_w_pc;

  logic [63:0] w_addr_raw;
  logic [63:0] w_addr;
  logic [2:0]  w_lsb_mask;
  logic [7:0]  w_size_mask;
  logic [7:0]  w_wmask;
  logic [63:0] w_wdata;
  logic [63:0] w_shifted;
  logic [63:0] w_load_data;
  logic        w_w_free;
`ifdef LSP_MISALIGN_TRAP_EN
  logic        w_misaligned;
  logic        r_misalign;
  logic [63:0] r_misalign_pc;
`endif

  assign w_addr_raw = ix_lsp_base + {{52{ix_lsp_offset[11]}}, ix_lsp_offset};
  assign w_w_free   = !r_w_valid || lsp_ix_ready;

  always_comb begin
    w_lsb_mask  = 3'b111;
    w_size_mask = 8'hff;
    w_wdata     = ix_lsp_source;
    case (ix_lsp_mem_width)
      2'd0: begin
        w_lsb_mask  = 3'b000;
        w_size_mask = 8'h01;
        w_wdata     = {8{ix_lsp_source[7:0]}};
      end
      2'd1: begin
        w_lsb_mask  = 3'b001;
        w_size_mask = 8'h03;
        w_wdata     = {4{ix_lsp_source[15:0]}};
      end
      2'd2: begin
        w_lsb_mask  = 3'b011;
        w_size_mask = 8'h0f;
        w_wdata     = {2{ix_lsp_source[31:0]}};
      end
      default: begin
        w_lsb_mask  = 3'b111;
        w_size_mask = 8'hff;
        w_wdata     = ix_lsp_source;
      end
    endcase
  end

`ifdef LSP_MISALIGN_TRAP_EN
  assign w_addr       = w_addr_raw;
  assign w_misaligned = |(w_addr_raw[2:0] & w_lsb_mask);
`else
  assign w_addr       = {w_addr_raw[63:3], w_addr_raw[2:0] & ~w_lsb_mask};
`endif

  // Aligned address keeps the shifted mask inside the 8 lanes.
  assign w_wmask = w_size_mask << w_addr[2:0];

  always_comb begin
    w_shifted   = dm_resp_rdata >> {r_addr[2:0], 3'b000};
    w_load_data = w_shifted;
    case (r_width)
      2'd0:    w_load_data = {{56{r_sign & w_shifted[7]}}, w_shifted[7:0]};
      2'd1:    w_load_data = {{48{r_sign & w_shifted[15]}}, w_shifted[15:0]};
      2'd2:    w_load_data = {{32{r_sign & w_shifted[31]}}, w_shifted[31:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_ready    <= 1'b0;
      r_addr     <= '0;
      r_wmask    <= '0;
      r_wdata    <= '0;
      r_width    <= '0;
      r_sign     <= 1'b0;
      r_dst      <= '0;
      r_pc       <= '0;
      r_wb_en    <= 1'b0;
      r_store    <= 1'b0;
      r_result   <= '0;
      r_w_valid  <= 1'b0;
      r_w_dst    <= '0;
      r_w_result <= '0;
      r_w_pc     <= '0;
`ifdef LSP_MISALIGN_TRAP_EN
      r_misalign    <= 1'b0;
      r_misalign_pc <= '0;
`endif
    end else begin
`ifdef LSP_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
      if (r_w_valid && lsp_ix_ready) r_w_valid <= 1'b0;

      case (r_state)
        StIdle: begin
          if (ix_lsp_valid && r_ready) begin
            r_addr  <= w_addr;
            r_wmask <= ix_lsp_wb_en ? 8'h00 : w_wmask;
            r_wdata <= w_wdata;
            r_width <= ix_lsp_mem_width;
            r_sign  <= ix_lsp_mem_sign;
            r_dst   <= ix_lsp_dst;
            r_pc    <= ix_lsp_pc;
            r_wb_en <= ix_lsp_wb_en;
            r_store <= !ix_lsp_wb_en;
            r_state <= StReq;
            r_ready <= 1'b0;
`ifdef LSP_MISALIGN_TRAP_EN
            if (w_misaligned) begin
              r_misalign    <= 1'b1;
              r_misalign_pc <= ix_lsp_pc;
              if (ix_lsp_wb_en) begin
                r_result <= '0;
                r_state  <= StHold;
              end else begin
                r_state <= StIdle;
                r_ready <= 1'b1;
              end
            end
`endif
          end else begin
            r_ready <= 1'b1;
          end
        end
        StReq: begin
          if (dm_req_ready) r_state <= StResp;
        end
        StResp: begin
          if (dm_resp_valid) begin
            if (r_store || !r_wb_en) begin
              r_state <= StIdle;
              r_ready <= 1'b1;
            end else if (w_w_free) begin
              r_w_valid  <= 1'b1;
              r_w_dst    <= r_dst;
              r_w_result <= w_load_data;
              r_w_pc     <= r_pc;
              r_state    <= StIdle;
              r_ready    <= 1'b1;
            end else begin
              r_result <= w_load_data;
              r_state  <= StHold;
            end
          end
        end
        default: begin  // StHold
          if (w_w_free) begin
            r_w_valid  <= 1'b1;
            r_w_dst    <= r_dst;
            r_w_result <= r_result;
            r_w_pc     <= r_pc;
            r_state    <= StIdle;
            r_ready    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign ix_lsp_ready     = r_ready;
  assign lsp_ix_mem_wb_en = (r_state != StIdle) && r_wb_en;
  assign lsp_ix_mem_dst   = r_dst;
  assign lsp_ix_valid     = r_w_valid;
  assign lsp_ix_wb_en     = r_w_valid;
  assign lsp_ix_dst       = r_w_dst;
  assign lsp_ix_result    = r_w_result;
  assign lsp_ix_pc        = r_w_pc;
  assign dm_req_valid     = (r_state == StReq);
  assign dm_req_addr      = r_addr;
  assign dm_req_wen       = r_store;
  assign dm_req_wdata     = r_wdata;
  assign dm_req_wmask     = r_wmask;
`ifdef LSP_MISALIGN_TRAP_EN
  assign lsp_misalign     = r_misalign;
  assign lsp_misalign_pc  = r_misalign_pc;
`endif

endmodule

// File: tb/tb_lsp.sv
module tb_lsp;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ix_lsp_pc;
  logic [4:0]  ix_lsp_dst;
  logic        ix_lsp_wb_en;
  logic [63:0] ix_lsp_base;
  logic [11:0] ix_lsp_offset;
  logic [63:0] ix_lsp_source;
  logic        ix_lsp_mem_sign;
  logic [1:0]  ix_lsp_mem_width;
  logic        ix_lsp_valid;
  logic        ix_lsp_ready;
  logic        lsp_ix_mem_wb_en;
  logic [4:0]  lsp_ix_mem_dst;
  logic [4:0]  lsp_ix_dst;
  logic [63:0] lsp_ix_result;
  logic [63:0] lsp_ix_pc;
  logic        lsp_ix_wb_en;
  logic        lsp_ix_valid;
  logic        lsp_ix_ready;
  logic        dm_req_valid;
  logic        dm_req_ready;
  logic [63:0] dm_req_addr;
  logic        dm_req_wen;
  logic [63:0] dm_req_wdata;
  logic [7:0]  dm_req_wmask;
  logic        dm_resp_valid;
  logic [63:0] dm_resp_rdata;

  always #5 clk = ~clk;

  lsp u_dut (
    .clk              (clk),
    .rst              (rst),
    .ix_lsp_pc        (ix_lsp_pc),
    .ix_lsp_dst       (ix_lsp_dst),
    .ix_lsp_wb_en     (ix_lsp_wb_en),
    .ix_lsp_base      (ix_lsp_base),
    .ix_lsp_offset    (ix_lsp_offset),
    .ix_lsp_source    (ix_lsp_source),
    .ix_lsp_mem_sign  (ix_lsp_mem_sign),
    .ix_lsp_mem_width (ix_lsp_mem_width),
    .ix_lsp_valid     (ix_lsp_valid),
    .ix_lsp_ready     (ix_lsp_ready),
    .lsp_ix_mem_wb_en (lsp_ix_mem_wb_en),
    .lsp_ix_mem_dst   (lsp_ix_mem_dst),
    .lsp_ix_dst       (lsp_ix_dst),
    .lsp_ix_result    (lsp_ix_result),
    .lsp_ix_pc        (lsp_ix_pc),
    .lsp_ix_wb_en     (lsp_ix_wb_en),
    .lsp_ix_valid     (lsp_ix_valid),
    .lsp_ix_ready     (lsp_ix_ready),
    .dm_req_valid     (dm_req_valid),
    .dm_req_ready     (dm_req_ready),
    .dm_req_addr      (dm_req_addr),
    .dm_req_wen       (dm_req_wen),
    .dm_req_wdata     (dm_req_wdata),
    .dm_req_wmask     (dm_req_wmask),
    .dm_resp_valid    (dm_resp_valid),
    .dm_resp_rdata    (dm_resp_rdata)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  wmask;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } req_t;

  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] pc;
  } wb_t;

  req_t rq[$];
  wb_t  wq[$];

  int total = 0;
  int bad = 0;
  int req_stall = 0;
  int resp_delay = 0;
  int wstall = 0;
  bit pend = 1'b0;
  bit saw_overlap = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory model: checks each request against the expected queue, answers after resp_delay.
  initial begin : mem_model
    int   rcnt;
    req_t r;
    logic [63:0] prdata;
    rcnt          = 0;
    prdata        = '0;
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    dm_resp_rdata = '0;
    forever begin
      @(negedge clk);
      dm_resp_valid = 1'b0;
      if (pend) begin
        if (rcnt == 0) begin
          dm_resp_valid = 1'b1;
          dm_resp_rdata = prdata;
          pend          = 1'b0;
        end else begin
          rcnt--;
        end
      end
      dm_req_ready = 1'b0;
      if (dm_req_valid === 1'b1 && !rst) begin
        if (req_stall > 0) begin
          req_stall--;
        end else begin
          dm_req_ready = 1'b1;
          if (rq.size() == 0) begin
            check("req_unexp", 1, 0);
          end else begin
            r = rq.pop_front();
            check("req_addr", dm_req_addr, r.addr);
            check("req_wen", dm_req_wen, r.wen);
            check("req_wmask", dm_req_wmask, r.wmask);
            if (r.wen) check("req_wdata", dm_req_wdata, r.wdata);
            prdata = r.rdata;
          end
          pend = 1'b1;
          rcnt = resp_delay;
        end
      end
    end
  end

  // Writeback consumer and scoreboard.
  initial begin : wb_mon
    wb_t e;
    lsp_ix_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (lsp_ix_valid === 1'b1 && wstall > 0) begin
        lsp_ix_ready = 1'b0;
        wstall--;
      end else begin
        lsp_ix_ready = 1'b1;
      end
      if (lsp_ix_valid === 1'b1 && lsp_ix_mem_wb_en === 1'b1) saw_overlap = 1'b1;
      if (lsp_ix_valid === 1'b1 && lsp_ix_ready && !rst) begin
        if (wq.size() == 0) begin
          check("wb_unexp", 1, 0);
        end else begin
          e = wq.pop_front();
          check("wb_dst", lsp_ix_dst, e.dst);
          check("wb_result", lsp_ix_result, e.result);
          check("wb_pc", lsp_ix_pc, e.pc);
          check("wb_en", lsp_ix_wb_en, 1);
        end
      end
    end
  end

  task automatic issue(input logic [63:0] pc, input logic [4:0] dst, input logic wb_en,
                       input logic [63:0] base, input logic [11:0] off, input logic [63:0] src,
                       input logic sign, input logic [1:0] width);
    int n;
    n = 0;
    @(negedge clk);
    while (ix_lsp_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("issue_rdy", ix_lsp_ready, 1);
    ix_lsp_pc        = pc;
    ix_lsp_dst       = dst;
    ix_lsp_wb_en     = wb_en;
    ix_lsp_base      = base;
    ix_lsp_offset    = off;
    ix_lsp_source    = src;
    ix_lsp_mem_sign  = sign;
    ix_lsp_mem_width = width;
    ix_lsp_valid     = 1'b1;
    @(posedge clk);
    #1 ix_lsp_valid = 1'b0;
  endtask

  task automatic load(input logic [63:0] pc, input logic [4:0] dst, input logic sign,
                      input logic [1:0] width, input logic [63:0] base, input logic [11:0] off,
                      input logic [63:0] exp_addr, input logic [63:0] rdata,
                      input logic [63:0] exp_res, input bit expect_wb);
    rq.push_back('{addr: exp_addr, wen: 1'b0, wmask: 8'h00, wdata: 64'h0, rdata: rdata});
    if (expect_wb) wq.push_back('{dst: dst, result: exp_res, pc: pc});
    issue(pc, dst, 1'b1, base, off, 64'h0, sign, width);
  endtask

  task automatic store(input logic [63:0] pc, input logic [1:0] width, input logic [63:0] base,
                       input logic [11:0] off, input logic [63:0] src,
                       input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                       input logic [63:0] exp_wdata);
    rq.push_back('{addr: exp_addr, wen: 1'b1, wmask: exp_mask, wdata: exp_wdata,
                   rdata: 64'h0});
    issue(pc, 5'd0, 1'b0, base, off, src, 1'b0, width);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((wq.size() != 0 || rq.size() != 0 || pend || ix_lsp_ready !== 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", (n < 100), 1);
  endtask

  initial begin : main
    rst              = 1'b1;
    ix_lsp_valid     = 1'b0;
    ix_lsp_pc        = '0;
    ix_lsp_dst       = '0;
    ix_lsp_wb_en     = 1'b0;
    ix_lsp_base      = '0;
    ix_lsp_offset    = '0;
    ix_lsp_source    = '0;
    ix_lsp_mem_sign  = 1'b0;
    ix_lsp_mem_width = '0;
    repeat (3) @(negedge clk);
    check("rst_req_valid", dm_req_valid, 0);
    check("rst_wb_valid", lsp_ix_valid, 0);
    check("rst_wb_en", lsp_ix_wb_en, 0);
    check("rst_mem_wb_en", lsp_ix_mem_wb_en, 0);
    check("rst_result", lsp_ix_result, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", ix_lsp_ready, 1);

    // LD, zero-wait latency
    load(64'h100, 5'd5, 1'b0, 2'd3, 64'h1000, 12'h010, 64'h1010, 64'h1122334455667788,
         64'h1122334455667788, 1);
    repeat (2) @(negedge clk);
    check("lat_pre", lsp_ix_valid, 0);
    @(negedge clk);
    check("lat_t3", lsp_ix_valid, 1);
    drain();

    // LB / LBU lane 2, negative offset
    load(64'h104, 5'd6, 1'b1, 2'd0, 64'h2003, 12'hfff, 64'h2002, 64'hA5A5_A5A5_A580_A5A5,
         64'hFFFF_FFFF_FFFF_FF80, 1);
    load(64'h108, 5'd6, 1'b0, 2'd0, 64'h2003, 12'hfff, 64'h2002, 64'hA5A5_A5A5_A580_A5A5,
         64'h0000_0000_0000_0080, 1);
    drain();

    // Stores: SW, plus H/B with low address bits aligned down
    store(64'h10c, 2'd2, 64'h3000, 12'h004, 64'h0000_0000_DEAD_BEEF, 64'h3004, 8'hF0,
          64'hDEAD_BEEF_DEAD_BEEF);
    drain();
    check("st_ready", ix_lsp_ready, 1);
    store(64'h110, 2'd1, 64'h7000, 12'h003, 64'h1234_5678_9ABC_BEEF, 64'h7002, 8'h0C,
          64'hBEEF_BEEF_BEEF_BEEF);
    store(64'h114, 2'd0, 64'h7000, 12'h007, 64'h0000_0000_0000_115A, 64'h7007, 8'h80,
          64'h5A5A_5A5A_5A5A_5A5A);
    load(64'h118, 5'd12, 1'b1, 2'd2, 64'h7000, 12'h006, 64'h7004, 64'h89AB_CDEF_0123_4567,
         64'hFFFF_FFFF_89AB_CDEF, 1);
    load(64'h11c, 5'd13, 1'b1, 2'd3, 64'h100, 12'h800, 64'hFFFF_FFFF_FFFF_F900,
         64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1);
    drain();

    // Request stall: in-flight destination visible until writeback
    req_stall = 3;
    load(64'h120, 5'd7, 1'b1, 2'd1, 64'h4000, 12'h006, 64'h4006, 64'h8001_0000_0000_0000,
         64'hFFFF_FFFF_FFFF_8001, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (lsp_ix_valid === 1'b1) begin
        check("stall_mem_wb_drop", lsp_ix_mem_wb_en, 0);
        break;
      end
      check("stall_mem_wb_en", lsp_ix_mem_wb_en, 1);
      check("stall_mem_dst", lsp_ix_mem_dst, 7);
      check("stall_ready", ix_lsp_ready, 0);
    end
    drain();

    // Writeback backpressure forces HOLD on the second load
    wstall = 4;
    load(64'h130, 5'd8, 1'b0, 2'd2, 64'h5000, 12'h004, 64'h5004, 64'hF000_0001_0000_0000,
         64'h0000_0000_F000_0001, 1);
    load(64'h134, 5'd9, 1'b1, 2'd2, 64'h5000, 12'h004, 64'h5004, 64'hF000_0001_0000_0000,
         64'hFFFF_FFFF_F000_0001, 1);
    drain();
    check("hold_overlap", saw_overlap, 1);

    // Reset while waiting for the response; late response must be ignored
    resp_delay = 3;
    load(64'h140, 5'd10, 1'b0, 2'd3, 64'h6000, 12'h000, 64'h6000, 64'hDEAD_DEAD_DEAD_DEAD,
         64'h0, 0);
    repeat (2) @(negedge clk);
    check("resp_state_req", dm_req_valid, 0);
    check("resp_state_mem", lsp_ix_mem_wb_en, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_req_valid", dm_req_valid, 0);
    check("mrst_wb_valid", lsp_ix_valid, 0);
    check("mrst_mem_wb_en", lsp_ix_mem_wb_en, 0);
    check("mrst_wb_en", lsp_ix_wb_en, 0);
    rst = 1'b0;
    resp_delay = 0;
    repeat (5) @(negedge clk);
    check("mrst_no_wb", lsp_ix_valid, 0);
    load(64'h144, 5'd11, 1'b0, 2'd3, 64'h6000, 12'h008, 64'h6008, 64'hCAFE_F00D_1234_5678,
         64'hCAFE_F00D_1234_5678, 1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
